// File: rtl/host_link_pkg.sv
// Shared types and constants for the host link responder.
//   state_e        : responder FSM states
//   HDR_WR_BIT     : header bit selecting write (1) or read (0)
//   HDR_RSV_BIT    : reserved header bit, must be 0
//   ADDR_W         : width of the register address field in the header
//   TIMEOUT_RESP   : response byte sent when the core never answers a read
package host_link_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWdata,
        StRdWait
    } state_e;

    localparam int unsigned HDR_WR_BIT  = 7;
    localparam int unsigned HDR_RSV_BIT = 6;
    localparam int unsigned ADDR_W      = 6;

    localparam logic [7:0] TIMEOUT_RESP = 8'hEE;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/host_link_responder_if.sv
// Signal bundle between the host pins, the responder and the core register file.
//   slave  : responder side (consumes host byte/strobe and core read data)
//   master : environment side (host pins and core register file)
interface host_link_responder_if;
    import host_link_pkg::*;

    logic [7:0]        host_data_i;
    logic              host_stb_i;
    logic              host_par_i;
    logic [7:0]        resp_data_o;
    logic              resp_stb_o;
    logic              busy_o;
    logic              err_o;
    logic [ADDR_W-1:0] reg_addr_o;
    logic [7:0]        reg_wdata_o;
    logic              reg_we_o;
    logic              reg_re_o;
    logic [7:0]        reg_rdata_i;
    logic              reg_rvalid_i;

    modport slave (
        input  host_data_i, host_stb_i, host_par_i, reg_rdata_i, reg_rvalid_i,
        output resp_data_o, resp_stb_o, busy_o, err_o,
        output reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o
    );

    modport master (
        output host_data_i, host_stb_i, host_par_i, reg_rdata_i, reg_rvalid_i,
        input  resp_data_o, resp_stb_o, busy_o, err_o,
        input  reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o
    );

endinterface

// File: rtl/host_link_sync.sv
// Multi-flop synchronizer for one asynchronous input, followed by a history
// flop so that any level change of the synchronized signal yields a one-cycle
// toggle event.
//   clk, rst     : clock and synchronous active-high reset (flops clear to 0)
//   async_in     : asynchronous input
//   level        : synchronized level, aligned with the toggle event
//   toggle       : one-cycle pulse on every change of the synchronized level
module host_link_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic toggle
);

    // chain[SYNC_STAGES-1] is the synchronized output, chain[SYNC_STAGES] its history.
    logic [SYNC_STAGES:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-1:0], async_in};
        end
    end

    assign level  = chain[SYNC_STAGES-1];
    assign toggle = chain[SYNC_STAGES] ^ chain[SYNC_STAGES-1];

endmodule

// File: rtl/host_link_responder.sv
// Byte-serial host link to a small core register file. The host sends a
// header byte (bit7 write/read, bit6 reserved, bits5:0 address), optionally
// followed by a data byte for writes. Reads are answered with one response
// byte, or TIMEOUT_RESP if the core does not answer within TIMEOUT cycles.
//   clk, rst : clock and synchronous active-high reset
//   bus      : host_link_responder_if.slave (host pins, response pins, core bus)
// Optional feature: define HOST_LINK_PARITY_EN to check odd parity on
// host_par_i; failing bytes are dropped and set err_o.
module host_link_responder
    import host_link_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input logic                   clk,
    input logic                   rst,
    host_link_responder_if.slave  bus
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic byte_evt;
    logic byte_ok;
    logic stb_lvl_unused;

    host_link_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_stb_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.host_stb_i),
        .level    (stb_lvl_unused),
        .toggle   (byte_evt)
    );

`ifdef HOST_LINK_PARITY_EN
    logic par_lvl;
    logic par_evt_unused;

    host_link_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_par_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.host_par_i),
        .level    (par_lvl),
        .toggle   (par_evt_unused)
    );

    assign byte_ok = odd_parity_ok(bus.host_data_i, par_lvl);
`else
    logic par_unused;
    assign par_unused = bus.host_par_i;
    assign byte_ok    = 1'b1;
`endif

    state_e            state_q;
    logic [CNT_W-1:0]  tmo_cnt_q;
    logic [7:0]        resp_data_q;
    logic              resp_stb_q;
    logic              busy_q;
    logic              err_q;
    logic [ADDR_W-1:0] reg_addr_q;
    logic [7:0]        reg_wdata_q;
    logic              reg_we_q;
    logic              reg_re_q;

    logic good_byte;
    assign good_byte = byte_evt && byte_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tmo_cnt_q   <= '0;
            resp_data_q <= '0;
            resp_stb_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
        end else begin
            reg_we_q <= 1'b0;
            reg_re_q <= 1'b0;

            // Parity failures are dropped in every state.
            if (byte_evt && !byte_ok) begin
                err_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (good_byte) begin
                        if (bus.host_data_i[HDR_RSV_BIT]) begin
                            err_q <= 1'b1;
                        end else begin
                            reg_addr_q <= bus.host_data_i[ADDR_W-1:0];
                            if (bus.host_data_i[HDR_WR_BIT]) begin
                                state_q <= StWdata;
                            end else begin
                                reg_re_q  <= 1'b1;
                                busy_q    <= 1'b1;
                                tmo_cnt_q <= '0;
                                state_q   <= StRdWait;
                            end
                        end
                    end
                end
                StWdata: begin
                    if (good_byte) begin
                        reg_wdata_q <= bus.host_data_i;
                        reg_we_q    <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                StRdWait: begin
                    if (good_byte) begin
                        err_q <= 1'b1;
                    end
                    // The read-pulse cycle itself is not sampled for rvalid.
                    if (!reg_re_q) begin
                        if (bus.reg_rvalid_i) begin
                            resp_data_q <= bus.reg_rdata_i;
                            resp_stb_q  <= ~resp_stb_q;
                            busy_q      <= 1'b0;
                            state_q     <= StIdle;
                        end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                            resp_data_q <= TIMEOUT_RESP;
                            resp_stb_q  <= ~resp_stb_q;
                            err_q       <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= StIdle;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.resp_data_o = resp_data_q;
    assign bus.resp_stb_o  = resp_stb_q;
    assign bus.busy_o      = busy_q;
    assign bus.err_o       = err_q;
    assign bus.reg_addr_o  = reg_addr_q;
    assign bus.reg_wdata_o = reg_wdata_q;
    assign bus.reg_we_o    = reg_we_q;
    assign bus.reg_re_o    = reg_re_q;

endmodule

// File: tb/tb_host_link_responder.sv
// Directed self-checking bench for host_link_responder (SYNC_STAGES=2, TIMEOUT=255).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_host_link_responder;

    logic clk;
    logic rst;

    host_link_responder_if bus_if ();

    host_link_responder #(
        .SYNC_STAGES (2),
        .TIMEOUT     (255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;
    int re_cnt   = 0;
    int overlap_cnt = 0;
    logic stb_lvl = 1'b0;
    logic exp_stb = 1'b0;

    // Pulse counters, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bus_if.reg_we_o) we_cnt++;
        if (bus_if.reg_re_o) re_cnt++;
        if (bus_if.reg_we_o && bus_if.reg_re_o) overlap_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a byte and toggle the strobe in the same step; parity is odd
    // unless good_par is 0.
    task automatic send_byte(input logic [7:0] b, input logic good_par);
        bus_if.host_data_i = b;
        bus_if.host_par_i  = good_par ? ~(^b) : (^b);
        stb_lvl            = ~stb_lvl;
        bus_if.host_stb_i  = stb_lvl;
    endtask

    task automatic do_reset();
        rst                 = 1'b1;
        stb_lvl             = 1'b0;
        bus_if.host_stb_i   = 1'b0;
        bus_if.reg_rvalid_i = 1'b0;
        wait_neg(3);
        rst     = 1'b0;
        exp_stb = 1'b0;
    endtask

    initial begin
        int we0;
        int re0;
        bus_if.host_data_i  = 8'h00;
        bus_if.host_par_i   = 1'b1;
        bus_if.host_stb_i   = 1'b0;
        bus_if.reg_rdata_i  = 8'h00;
        bus_if.reg_rvalid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        do_reset();

        // Reset state
        check_eq("rst_resp_data", bus_if.resp_data_o, 8'h00);
        check_eq("rst_resp_stb", bus_if.resp_stb_o, 1'b0);
        check_eq("rst_busy", bus_if.busy_o, 1'b0);
        check_eq("rst_err", bus_if.err_o, 1'b0);
        check_eq("rst_addr", bus_if.reg_addr_o, 6'd0);
        check_eq("rst_wdata", bus_if.reg_wdata_o, 8'h00);
        check_eq("rst_we", bus_if.reg_we_o, 1'b0);
        check_eq("rst_re", bus_if.reg_re_o, 1'b0);

        // Write frame 0x85, 0x3C
        send_byte(8'h85, 1'b1);
        wait_neg(4);
        check_eq("wr_hdr_addr", bus_if.reg_addr_o, 6'd5);
        send_byte(8'h3C, 1'b1);
        wait_neg(2);
        check_eq("wr_we_early", bus_if.reg_we_o, 1'b0);
        wait_neg(1);
        check_eq("wr_we", bus_if.reg_we_o, 1'b1);
        check_eq("wr_addr", bus_if.reg_addr_o, 6'd5);
        check_eq("wr_wdata", bus_if.reg_wdata_o, 8'h3C);
        wait_neg(1);
        check_eq("wr_we_once", bus_if.reg_we_o, 1'b0);
        check_eq("wr_we_cnt", we_cnt, 1);
        check_eq("wr_re_cnt", re_cnt, 0);

        // Read frame 0x05, core answers 0xA7
        send_byte(8'h05, 1'b1);
        wait_neg(3);
        check_eq("rd_re", bus_if.reg_re_o, 1'b1);
        check_eq("rd_addr", bus_if.reg_addr_o, 6'd5);
        check_eq("rd_busy", bus_if.busy_o, 1'b1);
        wait_neg(1);
        check_eq("rd_re_once", bus_if.reg_re_o, 1'b0);
        check_eq("rd_re_cnt", re_cnt, 1);
        wait_neg(2);
        bus_if.reg_rdata_i  = 8'hA7;
        bus_if.reg_rvalid_i = 1'b1;
        check_eq("rd_busy_wait", bus_if.busy_o, 1'b1);
        check_eq("rd_stb_wait", bus_if.resp_stb_o, exp_stb);
        wait_neg(1);
        bus_if.reg_rvalid_i = 1'b0;
        exp_stb = ~exp_stb;
        check_eq("rd_resp_data", bus_if.resp_data_o, 8'hA7);
        check_eq("rd_resp_stb", bus_if.resp_stb_o, exp_stb);
        check_eq("rd_busy_done", bus_if.busy_o, 1'b0);

        // rvalid outside RD_WAIT is ignored
        bus_if.reg_rdata_i  = 8'h11;
        bus_if.reg_rvalid_i = 1'b1;
        wait_neg(1);
        bus_if.reg_rvalid_i = 1'b0;
        wait_neg(1);
        check_eq("idle_rv_data", bus_if.resp_data_o, 8'hA7);
        check_eq("idle_rv_stb", bus_if.resp_stb_o, exp_stb);

        // Read timeout
        send_byte(8'h07, 1'b1);
        wait_neg(3);
        check_eq("tmo_re", bus_if.reg_re_o, 1'b1);
        check_eq("tmo_addr", bus_if.reg_addr_o, 6'd7);
        wait_neg(255);
        check_eq("tmo_stb_early", bus_if.resp_stb_o, exp_stb);
        check_eq("tmo_busy_early", bus_if.busy_o, 1'b1);
        check_eq("tmo_err_early", bus_if.err_o, 1'b0);
        wait_neg(1);
        exp_stb = ~exp_stb;
        check_eq("tmo_resp_data", bus_if.resp_data_o, 8'hEE);
        check_eq("tmo_resp_stb", bus_if.resp_stb_o, exp_stb);
        check_eq("tmo_err", bus_if.err_o, 1'b1);
        check_eq("tmo_busy", bus_if.busy_o, 1'b0);

        // Reserved header bit
        do_reset();
        we0 = we_cnt;
        re0 = re_cnt;
        send_byte(8'h45, 1'b1);
        wait_neg(4);
        check_eq("rsv_err", bus_if.err_o, 1'b1);
        check_eq("rsv_busy", bus_if.busy_o, 1'b0);
        check_eq("rsv_addr", bus_if.reg_addr_o, 6'd0);
        check_eq("rsv_we_cnt", we_cnt - we0, 0);
        check_eq("rsv_re_cnt", re_cnt - re0, 0);

        // Overrun during RD_WAIT
        do_reset();
        we0 = we_cnt;
        re0 = re_cnt;
        send_byte(8'h06, 1'b1);
        wait_neg(4);
        check_eq("ovr_busy0", bus_if.busy_o, 1'b1);
        check_eq("ovr_err0", bus_if.err_o, 1'b0);
        send_byte(8'h33, 1'b1);
        wait_neg(4);
        check_eq("ovr_err", bus_if.err_o, 1'b1);
        check_eq("ovr_busy", bus_if.busy_o, 1'b1);
        check_eq("ovr_addr", bus_if.reg_addr_o, 6'd6);
        check_eq("ovr_re_cnt", re_cnt - re0, 1);
        check_eq("ovr_we_cnt", we_cnt - we0, 0);
        bus_if.reg_rdata_i  = 8'h5A;
        bus_if.reg_rvalid_i = 1'b1;
        wait_neg(1);
        bus_if.reg_rvalid_i = 1'b0;
        exp_stb = ~exp_stb;
        check_eq("ovr_resp_data", bus_if.resp_data_o, 8'h5A);
        check_eq("ovr_resp_stb", bus_if.resp_stb_o, exp_stb);

`ifdef HOST_LINK_PARITY_EN
        // Bad parity byte is dropped, the same byte with good parity is accepted
        do_reset();
        we0 = we_cnt;
        send_byte(8'h85, 1'b0);
        wait_neg(4);
        check_eq("par_err", bus_if.err_o, 1'b1);
        check_eq("par_addr", bus_if.reg_addr_o, 6'd0);
        send_byte(8'h85, 1'b1);
        wait_neg(4);
        send_byte(8'h3C, 1'b1);
        wait_neg(3);
        check_eq("par_we", bus_if.reg_we_o, 1'b1);
        check_eq("par_wdata", bus_if.reg_wdata_o, 8'h3C);
        check_eq("par_addr_ok", bus_if.reg_addr_o, 6'd5);
        wait_neg(1);
        check_eq("par_we_cnt", we_cnt - we0, 1);
`endif

        // Reset in WDATA, then 0x3C becomes a read header
        do_reset();
        send_byte(8'h85, 1'b1);
        wait_neg(4);
        do_reset();
        we0 = we_cnt;
        re0 = re_cnt;
        check_eq("rwd_we", bus_if.reg_we_o, 1'b0);
        send_byte(8'h3C, 1'b1);
        wait_neg(3);
        check_eq("rwd_re", bus_if.reg_re_o, 1'b1);
        check_eq("rwd_addr", bus_if.reg_addr_o, 6'h3C);
        check_eq("rwd_busy", bus_if.busy_o, 1'b1);
        wait_neg(1);
        check_eq("rwd_we_cnt", we_cnt - we0, 0);
        check_eq("rwd_re_cnt", re_cnt - re0, 1);
        bus_if.reg_rdata_i  = 8'h00;
        bus_if.reg_rvalid_i = 1'b1;
        wait_neg(1);
        bus_if.reg_rvalid_i = 1'b0;

        // Strobe already high through reset still yields a byte event
        rst                = 1'b1;
        bus_if.host_data_i = 8'h45;
        bus_if.host_par_i  = ~(^bus_if.host_data_i);
        stb_lvl            = 1'b1;
        bus_if.host_stb_i  = 1'b1;
        wait_neg(3);
        check_eq("rsthi_err_in_rst", bus_if.err_o, 1'b0);
        rst = 1'b0;
        wait_neg(4);
        check_eq("rsthi_err", bus_if.err_o, 1'b1);

        check_eq("we_re_overlap", overlap_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
